// File: rtl/writeback_stage.sv
// Writeback stage with built-in MEM/WB register: result select, sub-word load extract/extend, misalign flag.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  stop,
    input  logic                  valid_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [1:0]            load_size_in,
    input  logic                  load_unsigned_in,
    input  logic [1:0]            byte_off_in,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] WR,
    output logic [DATA_W-1:0]     WD,
    output logic                  misalign_err,
    output logic [COUNT_W-1:0]    retired_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    state_t                       state_q, state_d;
    logic                         advance;
    logic                         capture;
    logic                         misalign_p0;
    logic signed [DATA_W-1:0]     wd_sel_p0;
    logic [REG_ADDR_W-1:0]        wr_p1;
    logic signed [DATA_W-1:0]     wd_p1;
    logic                         wen_p1;
    logic                         mis_p1;

    // Sub-word extraction assumes a 32-bit datapath (four little-endian lanes).
    function automatic logic signed [DATA_W-1:0] extract_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        off,
        input logic              uns
    );
        logic [DATA_W-1:0] lane;
        logic [15:0]       half;
        logic signed [DATA_W-1:0] r;
        lane = word >> {off, 3'b000};
        half = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = $signed({{(DATA_W-8){~uns & lane[7]}}, lane[7:0]});
            SIZE_HALF: r = $signed({{(DATA_W-16){~uns & half[15]}}, half});
            default:   r = $signed(word);
        endcase
        return r;
    endfunction

    assign advance     = ena & ~stop;
    assign capture     = advance & valid_in;
    assign misalign_p0 = mem_to_reg_in & (load_size_in == SIZE_HALF) & byte_off_in[0];
    assign wd_sel_p0   = mem_to_reg_in
                         ? extract_load(mem_data, load_size_in, byte_off_in, load_unsigned_in)
                         : $signed(alu_result);

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = valid_in ? FULL : EMPTY;
        end else if (state_q == FULL) begin
            state_d = HELD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM/WB boundary: a misaligned load keeps the previous WD and is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_p1  <= '0;
            wd_p1  <= '0;
            wen_p1 <= 1'b0;
            mis_p1 <= 1'b0;
        end else if (capture) begin
            wr_p1  <= rd_in;
            wen_p1 <= reg_write_in & ~misalign_p0;
            mis_p1 <= misalign_p0;
            if (!misalign_p0) begin
                wd_p1 <= wd_sel_p0;
            end
        end
    end

    // Strobes are qualified by FULL so a held instruction never writes twice.
    assign reg_write_out = (state_q == FULL) & wen_p1;
    assign misalign_err  = (state_q == FULL) & mis_p1;
    assign WR            = wr_p1;
    assign WD            = wd_p1;

`ifdef WB_RETIRE_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    // Counts on the edge entering FULL so the count includes the instruction now presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign retired_count = count_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        stop;
    logic        valid_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [1:0]  byte_off_in;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd_in;
    logic        reg_write_out;
    logic [4:0]  WR;
    logic [31:0] WD;
    logic        misalign_err;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
`ifdef WB_RETIRE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .ena(ena), .stop(stop), .valid_in(valid_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .byte_off_in(byte_off_in), .alu_result(alu_result), .mem_data(mem_data),
        .rd_in(rd_in), .reg_write_out(reg_write_out), .WR(WR), .WD(WD),
        .misalign_err(misalign_err), .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cnt_exp();
        return CNT_ON ? 32'(exp_cnt) : 32'd0;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                         input logic uns, input logic [1:0] off, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] rd);
        valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r; load_size_in = sz;
        load_unsigned_in = uns; byte_off_in = off; alu_result = alu; mem_data = mem; rd_in = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; stop = 1'b0;
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'hDEADBEEF, 32'hCAFEF00D, 5'd9);
        step(); step();
        checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL rst_rwo: got %b expected 0", reg_write_out); end
        checks++; if (WR !== 5'd0) begin errors++; $display("FAIL rst_wr: got %0d expected 0", WR); end
        checks++; if (WD !== 32'd0) begin errors++; $display("FAIL rst_wd: got %h expected 0", WD); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", misalign_err); end
        checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", retired_count); end
        drive(0, 1, 0, 2'b00, 0, 2'b00, 32'hDEADBEEF, 32'hCAFEF00D, 5'd9);
        rst = 1'b1;
        step();
        checks++; if (reg_write_out !== 1'b0 || WD !== 32'd0 || WR !== 5'd0) begin
            errors++; $display("FAIL rst_release: got rwo=%b WR=%0d WD=%h expected 0/0/0", reg_write_out, WR, WD); end
        checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL rst_release_cnt: got %0d expected 0", retired_count); end
    endtask

    task automatic test_alu();
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'hAAAAAAAA, 32'h11111111, 5'd0);
        step(); exp_cnt++;
        checks++; if (WR !== 5'd0 || WD !== 32'hAAAAAAAA) begin
            errors++; $display("FAIL alu_data: got WR=%0d WD=%h expected 0 AAAAAAAA", WR, WD); end
        checks++; if (reg_write_out !== 1'b1) begin errors++; $display("FAIL alu_rwo: got %b expected 1", reg_write_out); end
        checks++; if (retired_count !== cnt_exp()) begin errors++; $display("FAIL alu_cnt: got %0d expected %0d", retired_count, cnt_exp()); end
        drive(0, 1, 0, 2'b00, 0, 2'b00, 32'h12121212, 32'h0, 5'd3);
        step();
        checks++; if (reg_write_out !== 1'b0 || WD !== 32'hAAAAAAAA) begin
            errors++; $display("FAIL alu_bubble: got rwo=%b WD=%h expected 0 AAAAAAAA", reg_write_out, WD); end
        checks++; if (retired_count !== cnt_exp()) begin errors++; $display("FAIL alu_bubble_cnt: got %0d expected %0d", retired_count, cnt_exp()); end
    endtask

    task automatic test_byte_load();
        drive(1, 1, 1, 2'b10, 0, 2'b11, 32'h0, 32'h80123456, 5'd5);
        step(); exp_cnt++;
        checks++; if (WD !== 32'hFFFFFF80 || WR !== 5'd5 || reg_write_out !== 1'b1) begin
            errors++; $display("FAIL byte3_signed: got WD=%h WR=%0d rwo=%b expected FFFFFF80 5 1", WD, WR, reg_write_out); end
        drive(1, 1, 1, 2'b10, 1, 2'b11, 32'h0, 32'h80123456, 5'd6);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h00000080 || WR !== 5'd6) begin
            errors++; $display("FAIL byte3_unsigned: got WD=%h WR=%0d expected 00000080 6", WD, WR); end
        drive(1, 1, 1, 2'b10, 0, 2'b00, 32'h0, 32'h80123456, 5'd7);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h00000056) begin errors++; $display("FAIL byte0_signed: got %h expected 00000056", WD); end
        drive(1, 1, 1, 2'b10, 0, 2'b01, 32'h0, 32'h80123456, 5'd8);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h00000034) begin errors++; $display("FAIL byte1_signed: got %h expected 00000034", WD); end
        drive(1, 0, 1, 2'b00, 0, 2'b11, 32'h0, 32'h80123456, 5'd9);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h80123456 || reg_write_out !== 1'b0) begin
            errors++; $display("FAIL word_nowrite: got WD=%h rwo=%b expected 80123456 0", WD, reg_write_out); end
        checks++; if (retired_count !== cnt_exp()) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", retired_count, cnt_exp()); end
    endtask

    task automatic test_half_load();
        drive(1, 1, 1, 2'b01, 0, 2'b10, 32'h0, 32'h80123456, 5'd10);
        step(); exp_cnt++;
        checks++; if (WD !== 32'hFFFF8012 || reg_write_out !== 1'b1) begin
            errors++; $display("FAIL half_hi_signed: got WD=%h rwo=%b expected FFFF8012 1", WD, reg_write_out); end
        drive(1, 1, 1, 2'b01, 1, 2'b10, 32'h0, 32'h80123456, 5'd10);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h00008012) begin errors++; $display("FAIL half_hi_unsigned: got %h expected 00008012", WD); end
        drive(1, 1, 1, 2'b01, 0, 2'b00, 32'h0, 32'h80123456, 5'd11);
        step(); exp_cnt++;
        checks++; if (WD !== 32'h00003456) begin errors++; $display("FAIL half_lo_signed: got %h expected 00003456", WD); end
        drive(1, 1, 1, 2'b01, 0, 2'b01, 32'h0, 32'h80123456, 5'd12);
        step(); exp_cnt++;
        checks++; if (reg_write_out !== 1'b0 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL half_misalign: got rwo=%b mis=%b expected 0 1", reg_write_out, misalign_err); end
        checks++; if (WD !== 32'h00003456) begin errors++; $display("FAIL half_misalign_wd: got %h expected 00003456", WD); end
        checks++; if (retired_count !== cnt_exp()) begin errors++; $display("FAIL half_misalign_cnt: got %0d expected %0d", retired_count, cnt_exp()); end
        drive(0, 0, 0, 2'b00, 0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL half_misalign_pulse: got %b expected 0", misalign_err); end
    endtask

    task automatic test_stall();
        logic [31:0] held_cnt;
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'h55555555, 32'h0, 5'd1);
        step(); exp_cnt++;
        held_cnt = cnt_exp();
        checks++; if (reg_write_out !== 1'b1 || WR !== 5'd1 || WD !== 32'h55555555) begin
            errors++; $display("FAIL stall_load: got rwo=%b WR=%0d WD=%h expected 1 1 55555555", reg_write_out, WR, WD); end
        stop = 1'b1;
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'h99999999, 32'h0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (reg_write_out !== 1'b0 || WR !== 5'd1 || WD !== 32'h55555555) begin
                errors++; $display("FAIL stall_hold%0d: got rwo=%b WR=%0d WD=%h expected 0 1 55555555", i, reg_write_out, WR, WD); end
            checks++; if (retired_count !== held_cnt) begin
                errors++; $display("FAIL stall_cnt%0d: got %0d expected %0d", i, retired_count, held_cnt); end
        end
        stop = 1'b0; ena = 1'b0;
        step();
        checks++; if (reg_write_out !== 1'b0 || WD !== 32'h55555555) begin
            errors++; $display("FAIL ena_hold: got rwo=%b WD=%h expected 0 55555555", reg_write_out, WD); end
        ena = 1'b1;
        drive(0, 1, 0, 2'b00, 0, 2'b00, 32'h99999999, 32'h0, 5'd2);
        step();
        checks++; if (reg_write_out !== 1'b0 || WR !== 5'd1 || WD !== 32'h55555555) begin
            errors++; $display("FAIL stall_release: got rwo=%b WR=%0d WD=%h expected 0 1 55555555", reg_write_out, WR, WD); end
        step();
        checks++; if (reg_write_out !== 1'b0 || retired_count !== held_cnt) begin
            errors++; $display("FAIL stall_empty: got rwo=%b cnt=%0d expected 0 %0d", reg_write_out, retired_count, held_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'h12345678, 32'h0, 5'd7);
        step(); exp_cnt++;
        checks++; if (reg_write_out !== 1'b1 || WD !== 32'h12345678) begin
            errors++; $display("FAIL mid_load: got rwo=%b WD=%h expected 1 12345678", reg_write_out, WD); end
        stop = 1'b1;
        step();
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (WR !== 5'd0 || WD !== 32'd0 || reg_write_out !== 1'b0 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_async: got WR=%0d WD=%h rwo=%b mis=%b expected 0 0 0 0", WR, WD, reg_write_out, misalign_err); end
        checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", retired_count); end
        @(negedge clk);
        rst = 1'b1; stop = 1'b0;
        drive(0, 1, 0, 2'b00, 0, 2'b00, 32'h12345678, 32'h0, 5'd7);
        step();
        checks++; if (reg_write_out !== 1'b0 || WD !== 32'd0 || WR !== 5'd0) begin
            errors++; $display("FAIL mid_no_write: got rwo=%b WR=%0d WD=%h expected 0 0 0", reg_write_out, WR, WD); end
        drive(1, 1, 0, 2'b00, 0, 2'b00, 32'h0BADF00D, 32'h0, 5'd31);
        step(); exp_cnt++;
        checks++; if (reg_write_out !== 1'b1 || WR !== 5'd31 || WD !== 32'h0BADF00D || retired_count !== cnt_exp()) begin
            errors++; $display("FAIL mid_recover: got rwo=%b WR=%0d WD=%h cnt=%0d expected 1 31 0BADF00D %0d", reg_write_out, WR, WD, retired_count, cnt_exp()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte_load();
        test_half_load();
        test_stall();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
